vsync_hub: RTL and testbench
============================

VSYNC_HUB -- requirements
Module: vsync_hub

Interface
REQ-001 SHALL have parameter SyncDepth, default 8: maximum outstanding tokens per channel.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port mvWSync, input, 1: matrix array posts one M->V token.
REQ-005 SHALL have port mvRSync, input, 1: vector control consumes one M->V token.
REQ-006 SHALL have port mvEmpty, output, 1: M->V count is zero.
REQ-007 SHALL have port mvFull, output, 1: M->V count equals SyncDepth.
REQ-008 SHALL have ports evWSync/evRSync (input, 1) and evEmpty/evFull (output, 1), with the same meaning for the E->V channel.
REQ-009 SHALL have ports veWSync/veRSync (input, 1) and veEmpty/veFull (output, 1), with the same meaning for the V->E channel.
REQ-010 SHALL have port clrErr, input, 1: synchronous clear of all error bits.
REQ-011 SHALL have port syncErr, output, 3: sticky error bits; [0]=mv, [1]=ev, [2]=ve.

Function
REQ-012 SHALL keep one independent token counter per channel, width $clog2(SyncDepth+1), range 0..SyncDepth.
REQ-013 SHALL treat each W/R input as a single-cycle request sampled at the rising edge; a level held N cycles counts as N requests.
REQ-014 SHALL accept a write when count<SyncDepth and increment the count by 1 on that edge.
REQ-015 SHALL accept a read when count>0 and decrement the count by 1 on that edge.
REQ-016 SHALL, on simultaneous write and read with 0<count<SyncDepth, leave the count unchanged.
REQ-017 SHALL, on simultaneous write and read at count==SyncDepth, accept both; count stays SyncDepth and no error is raised.
REQ-018 SHALL, on simultaneous write and read at count==0, drop the read, accept the write (count becomes 1), and set that channel's error bit.
REQ-019 SHALL, on a write alone at count==SyncDepth, drop the write, hold the count, and set the error bit (overflow).
REQ-020 SHALL, on a read alone at count==0, drop the read, hold the count at 0 (no wrap), and set the error bit (underflow).
REQ-021 SHALL decode Empty/Full combinationally from the registered count only, never from same-cycle W/R inputs; an accepted write at edge N deasserts Empty from cycle N+1.
REQ-022 SHALL hold each syncErr bit at 1 until clrErr or reset; if clrErr coincides with a new error, the new error wins and the bit stays 1.
REQ-023 SHALL keep channels fully independent; activity on one channel never affects another.

Reset
REQ-024 SHALL, while rst_n is low, force all counts to 0, mvEmpty/evEmpty/veEmpty=1, all Full=0, and syncErr=3'b000, regardless of clock.
REQ-025 SHALL discard all outstanding tokens when reset is asserted mid-operation and ignore all W/R inputs until rst_n is high at a rising edge.

Structure
REQ-026 SHALL take SyncDepth from a constant in the shared Common package, alongside a SyncCh enum (MV=0, EV=1, VE=2) used to index syncErr.
REQ-027 SHALL instantiate one sub-module, SyncCnt, three times; SyncCnt holds the counter, Full/Empty decode and sticky error for one channel.
REQ-028 SHALL contain no other state beyond the three SyncCnt instances.

Verification
REQ-029 SHALL pass: 3 mvWSync pulses then 3 mvRSync pulses -> count 1,2,3,2,1,0; mvEmpty deasserts the cycle after the first write and reasserts after the last read.
REQ-030 SHALL pass: 9 consecutive evWSync with SyncDepth=8 -> evFull from cycle 9; 9th write dropped; syncErr=3'b010; count stays 8.
REQ-031 SHALL pass: veRSync on an empty channel -> count stays 0, syncErr[2]=1; then clrErr -> syncErr=0 next cycle.
REQ-032 SHALL pass: simultaneous W+R at count 0 -> count 1 and error bit set; at count 8 -> count 8 and no error; at count 4 -> count 4.
REQ-033 SHALL pass: fill mv to 5 and assert rst_n low between clock edges -> count 0, mvEmpty=1 immediately (asynchronous).
REQ-034 SHALL pass: interleaved random W/R on all three channels against a reference counter model -> exact match of counts and flags every cycle.

Source files
------------

// File: rtl/vsync_hub_pkg.sv
`default_nettype none
// ============================================================
// vsync_hub_pkg : shared constants and channel enum for vsync_hub
// Rev 1.0
// ============================================================
package vsync_hub_pkg;

   localparam int SYNC_DEPTH = 8;

   typedef enum logic [1:0] {
      MV = 2'd0,
      EV = 2'd1,
      VE = 2'd2
   } sync_ch_e;

endpackage
`default_nettype wire

// File: rtl/vsync_hub_if.sv
`default_nettype none
// ============================================================
// vsync_hub_if : token handshake and error bus of the sync hub
// Rev 1.0
// ============================================================
interface vsync_hub_if;

   logic       mvWSync;
   logic       mvRSync;
   logic       mvEmpty;
   logic       mvFull;
   logic       evWSync;
   logic       evRSync;
   logic       evEmpty;
   logic       evFull;
   logic       veWSync;
   logic       veRSync;
   logic       veEmpty;
   logic       veFull;
   logic       clrErr;
   logic [2:0] syncErr;

   modport master (
      output mvWSync, mvRSync, evWSync, evRSync, veWSync, veRSync, clrErr,
      input  mvEmpty, mvFull, evEmpty, evFull, veEmpty, veFull, syncErr
   );

   modport slave (
      input  mvWSync, mvRSync, evWSync, evRSync, veWSync, veRSync, clrErr,
      output mvEmpty, mvFull, evEmpty, evFull, veEmpty, veFull, syncErr
   );

endinterface
`default_nettype wire

// File: rtl/vsync_hub_sync_cnt.sv
`default_nettype none
// ============================================================
// SyncCnt : one token channel - counter, full/empty decode, sticky error
// Rev 1.0
// ============================================================
module SyncCnt #(
   parameter int Depth = 8
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic w_i,
   input  wire logic r_i,
   input  wire logic clr_i,
   output logic      empty_o,
   output logic      full_o,
   output logic      err_o
);

   localparam int CW = $clog2(Depth + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          full, empty, acc_w, acc_r, new_err;

   assign full  = (cnt_q == CW'(Depth));
   assign empty = (cnt_q == '0);

   // At full a paired read frees the slot the write needs, so both go through.
   assign acc_w   = w_i & (~full | r_i);
   assign acc_r   = r_i & ~empty;
   assign new_err = (w_i & ~r_i & full) | (r_i & empty);

   always_comb begin
      cnt_d = cnt_q;
      if (acc_w && !acc_r) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!acc_w && acc_r) begin
         cnt_d = cnt_q - CW'(1);
      end
      err_d = new_err | (err_q & ~clr_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign empty_o = empty;
   assign full_o  = full;
   assign err_o   = err_q;

endmodule
`default_nettype wire

// File: rtl/vsync_hub.sv
`default_nettype none
// ============================================================
// vsync_hub : three independent token channels (M->V, E->V, V->E)
// Rev 1.0
// ============================================================
module vsync_hub
   import vsync_hub_pkg::*;
#(
   parameter int SyncDepth = SYNC_DEPTH
) (
   input wire logic clk,
   input wire logic rst_n,
   vsync_hub_if.slave bus
);

   logic [2:0] err;

   SyncCnt #(.Depth(SyncDepth)) u_mv (
      .clk(clk), .rst_n(rst_n),
      .w_i(bus.mvWSync), .r_i(bus.mvRSync), .clr_i(bus.clrErr),
      .empty_o(bus.mvEmpty), .full_o(bus.mvFull), .err_o(err[MV])
   );

   SyncCnt #(.Depth(SyncDepth)) u_ev (
      .clk(clk), .rst_n(rst_n),
      .w_i(bus.evWSync), .r_i(bus.evRSync), .clr_i(bus.clrErr),
      .empty_o(bus.evEmpty), .full_o(bus.evFull), .err_o(err[EV])
   );

   SyncCnt #(.Depth(SyncDepth)) u_ve (
      .clk(clk), .rst_n(rst_n),
      .w_i(bus.veWSync), .r_i(bus.veRSync), .clr_i(bus.clrErr),
      .empty_o(bus.veEmpty), .full_o(bus.veFull), .err_o(err[VE])
   );

   assign bus.syncErr = err;

endmodule
`default_nettype wire

// File: tb/tb_vsync_hub.sv
`default_nettype none
// ============================================================
// tb_vsync_hub : scoreboard bench for vsync_hub
// Rev 1.0
// ============================================================
module tb_vsync_hub;
   import vsync_hub_pkg::*;

   localparam int D = 8;

   typedef struct packed {
      logic [3:0] c_mv;
      logic [3:0] c_ev;
      logic [3:0] c_ve;
      logic [2:0] err;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   mcnt [3];
   logic [2:0] merr;
   exp_t sb_q [$];

   vsync_hub_if bus ();

   vsync_hub #(.SyncDepth(D)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp_v);
      n_tests++;
      if (obs != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Compares counts, flags and errors against one expected snapshot.
   task automatic compare(input exp_t e);
      check("mv_cnt",   int'(dut.u_mv.cnt_q), int'(e.c_mv));
      check("ev_cnt",   int'(dut.u_ev.cnt_q), int'(e.c_ev));
      check("ve_cnt",   int'(dut.u_ve.cnt_q), int'(e.c_ve));
      check("mvEmpty",  int'(bus.mvEmpty), int'(e.c_mv == 0));
      check("mvFull",   int'(bus.mvFull),  int'(e.c_mv == D));
      check("evEmpty",  int'(bus.evEmpty), int'(e.c_ev == 0));
      check("evFull",   int'(bus.evFull),  int'(e.c_ev == D));
      check("veEmpty",  int'(bus.veEmpty), int'(e.c_ve == 0));
      check("veFull",   int'(bus.veFull),  int'(e.c_ve == D));
      check("syncErr",  int'(bus.syncErr), int'(e.err));
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.c_mv = 4'(mcnt[0]);
      e.c_ev = 4'(mcnt[1]);
      e.c_ve = 4'(mcnt[2]);
      e.err  = merr;
      return e;
   endfunction

   task automatic model_ch(input int ch, input logic w, input logic r, input logic clr);
      int  c;
      logic e;
      c = mcnt[ch];
      e = 1'b0;
      if (w && r) begin
         if (c == 0) begin
            c = 1;
            e = 1'b1;
         end
      end else if (w) begin
         if (c == D) e = 1'b1;
         else        c = c + 1;
      end else if (r) begin
         if (c == 0) e = 1'b1;
         else         c = c - 1;
      end
      mcnt[ch] = c;
      if (e)        merr[ch] = 1'b1;
      else if (clr) merr[ch] = 1'b0;
   endtask

   // One clock of stimulus; the expected result is queued then checked after the edge.
   task automatic step(input logic mw, input logic mr, input logic ew, input logic er,
                       input logic vw, input logic vr, input logic clr);
      exp_t e;
      bus.mvWSync = mw; bus.mvRSync = mr;
      bus.evWSync = ew; bus.evRSync = er;
      bus.veWSync = vw; bus.veRSync = vr;
      bus.clrErr  = clr;
      model_ch(0, mw, mr, clr);
      model_ch(1, ew, er, clr);
      model_ch(2, vw, vr, clr);
      sb_q.push_back(snap());
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      compare(e);
      bus.mvWSync = 1'b0; bus.mvRSync = 1'b0;
      bus.evWSync = 1'b0; bus.evRSync = 1'b0;
      bus.veWSync = 1'b0; bus.veRSync = 1'b0;
      bus.clrErr  = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) mcnt[i] = 0;
      merr = 3'b000;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_reset();
      bus.mvWSync = 1'b0; bus.mvRSync = 1'b0;
      bus.evWSync = 1'b0; bus.evRSync = 1'b0;
      bus.veWSync = 1'b0; bus.veRSync = 1'b0;
      bus.clrErr  = 1'b0;
      rst_n = 1'b0;
      #23;
      compare(snap());
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // mv: three writes then three reads
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);

      // ev: nine writes, last one overflows
      for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, 0, 0);
      check("ev_overflow_err", int'(bus.syncErr), 2);
      step(0, 0, 0, 0, 0, 0, 1);

      // ve: underflow then clear
      step(0, 0, 0, 0, 0, 1, 0);
      check("ve_underflow_err", int'(bus.syncErr[VE]), 1);
      step(0, 0, 0, 0, 0, 0, 1);
      check("ve_err_cleared", int'(bus.syncErr), 0);

      // clear racing a new error: error wins
      step(0, 0, 0, 0, 0, 1, 1);

      // simultaneous W+R on mv at 0, at full, at mid
      step(0, 0, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);

      // drain everything and clear, then async reset with mv at 5
      for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_mv_cnt", int'(dut.u_mv.cnt_q), 0);
      check("async_rst_mvEmpty", int'(bus.mvEmpty), 1);
      bus.mvWSync = 1'b1;
      @(posedge clk);
      #1;
      compare(snap());
      bus.mvWSync = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // random traffic on all channels
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
